// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the boot sequencer: FSM states, header length
// and the word-index width helper.
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_RUN,
        S_HALTED
    } boot_state_t;

    // Header and payload words are both 4 little-endian bytes.
    localparam int HDR_BYTES = 4;

    // Index counts 0..max_words inclusive.
    function automatic int idx_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler: drops each byte into its lane and pulses
// word_done in the same cycle the 4th byte is accepted.
module boot_word_asm
    import cpu_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int BW = $clog2(HDR_BYTES);
    localparam logic [BW-1:0] LAST_LANE = BW'(HDR_BYTES - 1);

    logic [BW-1:0]   byte_cnt;
    logic [2:0][7:0] lanes;

    // The top lane is never stored: it is taken straight from the bus.
    assign word_done = accept && (byte_cnt == LAST_LANE);
    assign word      = {byte_in, lanes};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // NOTE: lanes are pure data qualified by byte_cnt, so they carry no reset;
    // clearing the counter is enough to discard a partial word.
    always_ff @(posedge clk) begin
        if (accept && !word_done) begin
            lanes[byte_cnt] <= byte_in;
        end
    end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed image from the UART into the core
// through its boot port while holding it in reset, then runs it until halt.
module cpu_boot_ctrl
    import cpu_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 8192,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        halt,
    output logic        cpu_rst_n,
    output logic        debug,
    output logic [31:0] boot_addr,
    output logic [31:0] boot_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IW = idx_width(MAX_WORDS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]   MAX_N    = 32'(MAX_WORDS);

    boot_state_t   state, next_state;
    logic          fire, start, tmo_hit, word_done, last_word;
    logic [31:0]   word;
    logic [IW-1:0] idx, idx_inc, n_words;
    logic [TW-1:0] tmo_cnt;

    assign rx_ready  = (state != S_RUN);
    assign busy      = (state == S_HDR) || (state == S_DATA);
    assign fire      = rx_valid && rx_ready;
    assign start     = fire && ((state == S_IDLE) || (state == S_HALTED));
    assign tmo_hit   = busy && !fire && (tmo_cnt == TMO_LAST);
    assign idx_inc   = idx + 1'b1;
    assign last_word = (idx_inc == n_words);

    boot_word_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmo_hit),
        .accept    (fire),
        .byte_in   (rx_data),
        .word      (word),
        .word_done (word_done)
    );

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_HALTED: if (fire) next_state = S_HDR;
            S_HDR: begin
                if (tmo_hit) begin
                    next_state = S_IDLE;
                end else if (word_done) begin
                    if (word == '0)        next_state = S_RUN;
                    else if (word > MAX_N) next_state = S_IDLE;
                    else                   next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (tmo_hit)                     next_state = S_IDLE;
                else if (word_done && last_word) next_state = S_RUN;
            end
            S_RUN:   if (halt) next_state = S_HALTED;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cpu_rst_n <= 1'b0;
            debug     <= 1'b0;
            boot_addr <= BASE_ADDR;
            boot_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            n_words   <= '0;
            tmo_cnt   <= '0;
        end else begin
            state <= next_state;
            debug <= 1'b0;

            // After the last strobe the core leaves reset one cycle later than
            // the RUN entry; an empty image releases it immediately.
            cpu_rst_n <= ((next_state == S_RUN) || (next_state == S_HALTED))
                         && (state != S_DATA);

            if (busy && !fire && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            else                           tmo_cnt <= '0;

            if (busy && (next_state == S_IDLE)) err <= 1'b1;
            else if (start)                     err <= 1'b0;

            if ((state == S_RUN) && halt) done <= 1'b1;
            else if (start)               done <= 1'b0;

            if ((state == S_HDR) && word_done) begin
                idx     <= '0;
                n_words <= word[IW-1:0];
            end

            if ((state == S_DATA) && word_done) begin
                debug     <= 1'b1;
                boot_data <= word;
                boot_addr <= BASE_ADDR + (32'(idx) << 2);
                idx       <= idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: exact-timing hand sequences, a vector
// table of image shapes and randomized images against a write scoreboard.
module tb_cpu_boot_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 8192;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic        cpu_rst_n;
    logic        debug;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    typedef struct {
        logic [31:0] n_hdr;
        int          words;
        int          partial;
        int          silence;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    cpu_boot_ctrl #(
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .halt      (halt),
        .cpu_rst_n (cpu_rst_n),
        .debug     (debug),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always @(negedge clk) begin
        if (debug) begin
            got_addr.push_back(boot_addr);
            got_data.push_back(boot_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) idle(int'($urandom_range(0, 3)));
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic bit image_runs(input logic [31:0] n, input int words);
        return (n == 0) || ((n <= 32'(MAXW)) && (words == int'(n)));
    endfunction

    task automatic clear_queues();
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic compare_writes(input string name);
        check($sformatf("%s_nwrites", name), 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
        end
    endtask

    // Sends one image; expectations come from the image rules alone.
    task automatic run_image(input logic [31:0] n_hdr, input int words, input int partial,
                             input int silence, input bit gaps);
        bit          ok_n, exp_run, exp_err;
        logic [31:0] hv, dv;
        ok_n    = (n_hdr <= 32'(MAXW));
        exp_run = image_runs(n_hdr, words);
        exp_err = !ok_n || (!exp_run && silence >= TMO);
        clear_queues();
        hv = n_hdr;
        for (int i = 0; i < 4; i++) begin
            send_byte(hv[8*i +: 8], gaps);
            if (i == 0) begin
                check("first_busy", busy, 1);
                check("first_done", done, 0);
                check("first_err", err, 0);
                check("first_cpu_rst_n", cpu_rst_n, 0);
            end
        end
        check("hdr_busy", busy, ok_n && (n_hdr != 0));
        check("hdr_err", err, !ok_n);
        check("hdr_cpu_rst_n", cpu_rst_n, n_hdr == 0);
        for (int w = 0; w < words; w++) begin
            dv = $urandom;
            exp_addr.push_back(BASE + 32'(4 * w));
            exp_data.push_back(dv);
            for (int b = 0; b < 4; b++) send_byte(dv[8*b +: 8], gaps);
        end
        for (int p = 0; p < partial; p++) send_byte(8'($urandom), gaps);
        idle(2 + silence);
        compare_writes("image");
        check("final_err", err, exp_err);
        check("final_cpu_rst_n", cpu_rst_n, exp_run);
        check("final_busy", busy, !exp_run && !exp_err);
    endtask

    // Core is running: stray UART traffic must be ignored until halt.
    task automatic halt_seq(input int cyc);
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < cyc; i++) begin
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b0;
        check("run_rx_ready", rx_ready, 0);
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_done", done, 0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_done", done, 1);
        check("halt_rx_ready", rx_ready, 1);
        check("halt_cpu_rst_n", cpu_rst_n, 1);
        check("halt_busy", busy, 0);
        check("run_no_writes", 32'(got_addr.size()), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_debug"}, debug, 0);
        check({tag, "_boot_addr"}, boot_addr, BASE);
        check({tag, "_boot_data"}, boot_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rx_ready"}, rx_ready, 1);
    endtask

    initial begin
        logic [7:0] seq_a [12];
        logic [7:0] seq_b [6];
        int         n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        halt     = 1'b0;

        vecs[0] = '{32'd2,          2, 0, 0};
        vecs[1] = '{32'd0,          0, 0, 0};
        vecs[2] = '{32'd8193,       0, 0, 0};
        vecs[3] = '{32'd8192,       0, 0, TMO + 4};
        vecs[4] = '{32'd1,          0, 3, TMO + 4};
        vecs[5] = '{32'd3,          3, 0, 0};
        vecs[6] = '{32'hFFFF_FFFF,  0, 0, 0};

        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("idle_halt_done", done, 0);
        check("idle_halt_cpu_rst_n", cpu_rst_n, 0);
        check("idle_halt_busy", busy, 0);

        // Back-to-back two-word image with exact strobe and release timing.
        seq_a = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE};
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < 12; i++) begin
            rx_valid = 1'b1;
            rx_data  = seq_a[i];
            tick();
            if (i < 11) check($sformatf("a_busy%0d", i), busy, 1);
            if (i == 7) begin
                check("a_debug0", debug, 1);
                check("a_addr0", boot_addr, BASE);
                check("a_data0", boot_data, 32'h1234_5678);
            end else if (i == 11) begin
                check("a_debug1", debug, 1);
                check("a_addr1", boot_addr, BASE + 32'd4);
                check("a_data1", boot_data, 32'hDEAD_BEEF);
                check("a_strobe_cpu_rst_n", cpu_rst_n, 0);
            end else begin
                check($sformatf("a_nodebug%0d", i), debug, 0);
            end
        end
        rx_valid = 1'b0;
        tick();
        check("a_debug_end", debug, 0);
        check("a_cpu_rst_n", cpu_rst_n, 1);
        check("a_busy_end", busy, 0);
        check("a_rx_ready", rx_ready, 0);
        check("a_hold_data", boot_data, 32'hDEAD_BEEF);
        check("a_nwrites", 32'(got_addr.size()), 2);
        halt_seq(50);

        // Timeout after a partial word: err exactly after TMO idle cycles.
        seq_b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        for (int i = 0; i < 6; i++) send_byte(seq_b[i], 1'b0);
        idle(TMO - 1);
        check("b_err_early", err, 0);
        check("b_busy_early", busy, 1);
        idle(1);
        check("b_err", err, 1);
        check("b_busy", busy, 0);
        check("b_cpu_rst_n", cpu_rst_n, 0);
        check("b_rx_ready", rx_ready, 1);
        run_image(32'd1, 1, 0, 0, 1'b0);
        halt_seq(5);

        // Reset in the middle of word 0, while its 4th byte is on the bus.
        for (int i = 0; i < 4; i++) send_byte(seq_a[i], 1'b0);
        for (int i = 4; i < 7; i++) send_byte(seq_a[i], 1'b0);
        got_addr.delete();
        got_data.delete();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        tick();
        rx_valid = 1'b0;
        check_reset_values("midrst");
        rst = 1'b0;
        idle(3);
        check("midrst_nwrites", 32'(got_addr.size()), 0);
        run_image(32'd2, 2, 0, 0, 1'b0);
        halt_seq(3);

        for (int v = 0; v < 7; v++) begin
            run_image(vecs[v].n_hdr, vecs[v].words, vecs[v].partial, vecs[v].silence, 1'b1);
            if (image_runs(vecs[v].n_hdr, vecs[v].words)) halt_seq(4);
        end

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(0, 5));
            run_image(32'(n), n, 0, 0, 1'b1);
            halt_seq(int'($urandom_range(1, 8)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
